// File: rtl/axi_rd_channel_mo_if.sv
// AXI read-address / read-data bundle used by the bridge read channel.
// master: drives AR fields, arvalid and rready; samples arready and R fields.
// slave : the opposite side (AXI interconnect or testbench slave model).
interface axi_rd_channel_mo_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_channel_mo.sv
// Multi-outstanding read channel of the SRAM-to-AXI bridge.
// Arbitrates instruction and data SRAM-like reads onto one AXI AR channel
// (data reads have fixed priority) and steers R beats back by AXI ID.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   inst_sram_*         : instruction fetch port (req/size/addr in, addr_ok/data_ok/rdata out)
//   data_sram_*         : data port; writes (data_sram_wr=1) are ignored here
//   axi                 : AXI AR + R channel bundle (master side)
//   rd_outstanding      : any read accepted but not yet returned
module axi_rd_channel_mo #(
  parameter int unsigned OUTSTANDING = 4,
  parameter logic [3:0]  ID_INST     = 4'd0,
  parameter logic [3:0]  ID_DATA     = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  axi_rd_channel_mo_if.master axi,
  output logic        rd_outstanding
);

  localparam int unsigned   CW      = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);

  logic          arvalid_q, arvalid_d;
  logic [3:0]    arid_q, arid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [2:0]    arsize_q, arsize_d;
  logic [CW-1:0] cnt_inst_q, cnt_inst_d;
  logic [CW-1:0] cnt_data_q, cnt_data_d;
  logic          rready_q, rready_d;
  logic          inst_data_ok_q, inst_data_ok_d;
  logic          data_data_ok_q, data_data_ok_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;

  logic slot_free, inst_elig, data_elig, inst_acc, data_acc;
  logic r_hs, r_inst, r_data;
  logic unused_r;

  // rresp is ignored and every beat is treated as the last one.
  assign unused_r = ^{axi.rresp, axi.rlast};

  always_comb begin
    slot_free = ~arvalid_q | axi.arready;
    data_elig = data_sram_req & ~data_sram_wr & (cnt_data_q < CNT_MAX);
    inst_elig = inst_sram_req & (cnt_inst_q < CNT_MAX);
    data_acc  = slot_free & data_elig;
    inst_acc  = slot_free & inst_elig & ~data_elig;

    // rready_q (a flop) gates the handshake, so rvalid never reaches addr_ok.
    r_hs   = axi.rvalid & rready_q;
    r_inst = r_hs & (axi.rid == ID_INST);
    r_data = r_hs & (axi.rid == ID_DATA);

    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    if (data_acc) begin
      arvalid_d = 1'b1;
      arid_d    = ID_DATA;
      araddr_d  = data_sram_addr;
      arsize_d  = {1'b0, data_sram_size};
    end else if (inst_acc) begin
      arvalid_d = 1'b1;
      arid_d    = ID_INST;
      araddr_d  = inst_sram_addr;
      arsize_d  = {1'b0, inst_sram_size};
    end else if (slot_free) begin
      arvalid_d = 1'b0;
    end

    // Accept and return for the same ID in one cycle cancel out.
    cnt_inst_d = cnt_inst_q;
    case ({inst_acc, r_inst})
      2'b10:   cnt_inst_d = cnt_inst_q + CW'(1);
      2'b01:   cnt_inst_d = cnt_inst_q - CW'(1);
      default: cnt_inst_d = cnt_inst_q;
    endcase
    cnt_data_d = cnt_data_q;
    case ({data_acc, r_data})
      2'b10:   cnt_data_d = cnt_data_q + CW'(1);
      2'b01:   cnt_data_d = cnt_data_q - CW'(1);
      default: cnt_data_d = cnt_data_q;
    endcase

    rready_d       = 1'b1;
    inst_data_ok_d = r_inst;
    data_data_ok_d = r_data;
    inst_rdata_d   = r_inst ? axi.rdata : inst_rdata_q;
    data_rdata_d   = r_data ? axi.rdata : data_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q      <= 1'b0;
      arid_q         <= '0;
      araddr_q       <= '0;
      arsize_q       <= '0;
      cnt_inst_q     <= '0;
      cnt_data_q     <= '0;
      rready_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      arvalid_q      <= arvalid_d;
      arid_q         <= arid_d;
      araddr_q       <= araddr_d;
      arsize_q       <= arsize_d;
      cnt_inst_q     <= cnt_inst_d;
      cnt_data_q     <= cnt_data_d;
      rready_q       <= rready_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_acc;
  assign inst_sram_data_ok = inst_data_ok_q;
  assign data_sram_data_ok = data_data_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign rd_outstanding = (cnt_inst_q != '0) | (cnt_data_q != '0) | arvalid_q;

endmodule

// File: tb/tb_axi_rd_channel_mo.sv
// Bench for axi_rd_channel_mo: directed scenarios followed by a randomized
// run against a behavioural AXI slave, with a scoreboard monitor.
module tb_axi_rd_channel_mo;
  localparam int unsigned OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, data_sram_req, data_sram_wr;
  logic [1:0]  inst_sram_size, data_sram_size;
  logic [31:0] inst_sram_addr, data_sram_addr;
  logic        inst_sram_addr_ok, data_sram_addr_ok;
  logic        inst_sram_data_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        rd_outstanding;

  axi_rd_channel_mo_if axi();

  axi_rd_channel_mo #(.OUTSTANDING(OUT), .ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .axi               (axi),
    .rd_outstanding    (rd_outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D_8000;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  logic [38:0] ar_q[$];
  int n_i, n_d;  // reads accepted minus data_ok seen, per port

  always @(negedge clk) begin
    if (reset) begin
      q_i.delete(); q_d.delete(); ar_q.delete();
      n_i = 0; n_d = 0;
    end else begin
      if (inst_sram_data_ok) begin
        if (q_i.size() == 0) check("inst_extra_data_ok", 1, 0);
        else check("inst_rdata", inst_sram_rdata, q_i.pop_front());
        n_i--;
      end
      if (data_sram_data_ok) begin
        if (q_d.size() == 0) check("data_extra_data_ok", 1, 0);
        else check("data_rdata", data_sram_rdata, q_d.pop_front());
        n_d--;
      end
      if (axi.arvalid && axi.arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar_fields", {axi.arid, axi.araddr, axi.arsize}, ar_q.pop_front());
        check("ar_const", {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
              {8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
      end
      check("both_addr_ok", inst_sram_addr_ok & data_sram_addr_ok, 0);
      if (data_sram_addr_ok) begin
        check("data_ok_is_read", data_sram_req & ~data_sram_wr, 1);
        check("data_ok_limit", n_d < OUT, 1);
        q_d.push_back(mem(data_sram_addr));
        ar_q.push_back({4'd1, data_sram_addr, 1'b0, data_sram_size});
        n_d++;
      end
      if (inst_sram_addr_ok) begin
        check("inst_ok_req", inst_sram_req, 1);
        check("inst_ok_limit", n_i < OUT, 1);
        // An eligible data read would have won the slot.
        check("inst_ok_prio", data_sram_req & ~data_sram_wr & (n_d < OUT), 0);
        q_i.push_back(mem(inst_sram_addr));
        ar_q.push_back({4'd0, inst_sram_addr, 1'b0, inst_sram_size});
        n_i++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One R beat, presented for one cycle; returns just after the edge that took it.
  task automatic ret(input logic [3:0] id, input logic [31:0] addr);
    cyc();
    axi.rvalid = 1'b1; axi.rid = id; axi.rdata = mem(addr);
    axi.rresp = 2'($urandom); axi.rlast = 1'($urandom);
    cyc();
    axi.rvalid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_arvalid"}, axi.arvalid, 0);
    check({tag, "_arfields"}, {axi.arid, axi.araddr, axi.arsize}, 0);
    check({tag, "_rready"}, axi.rready, 0);
    check({tag, "_data_ok"}, {inst_sram_data_ok, data_sram_data_ok}, 0);
    check({tag, "_rdata"}, {inst_sram_rdata, data_sram_rdata}, 0);
    check({tag, "_rd_out"}, rd_outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] pend_i[$];
  logic [31:0] pend_d[$];

  initial begin
    int cnt;
    int sel;
    bit gen;
    bit drained;

    reset = 1'b1;
    inst_sram_req = 0; inst_sram_size = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1;

    // Reset state
    cyc(); cyc(); smp();
    check_reset_vals("rst");
    cyc(); reset = 1'b0;
    cyc(); smp();
    check("rready_after_reset", axi.rready, 1);

    // Single instruction read
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2; axi.arready = 1;
    smp(); check("single_addr_ok", inst_sram_addr_ok, 1);
    check("single_data_no_ok", data_sram_addr_ok, 0);
    cyc(); inst_sram_req = 0;
    smp(); check("single_ar", {axi.arvalid, axi.arid, axi.araddr, axi.arsize}, {1'b1, 4'd0, 32'hBFC0_0000, 3'd2});
    check("single_rd_out1", rd_outstanding, 1);
    cyc(); smp(); check("single_ar_clear", axi.arvalid, 0);
    check("single_rd_out2", rd_outstanding, 1);
    cyc();
    cyc(); axi.rvalid = 1; axi.rid = 0; axi.rdata = mem(32'hBFC0_0000);
    smp(); check("single_no_early_ok", inst_sram_data_ok, 0);
    cyc(); axi.rvalid = 0;
    smp(); check("single_data_ok", inst_sram_data_ok, 1);
    check("single_rdata", inst_sram_rdata, mem(32'hBFC0_0000));
    check("single_rd_out_fall", rd_outstanding, 0);
    cyc(); smp(); check("single_pulse", inst_sram_data_ok, 0);
    check("single_rdata_hold", inst_sram_rdata, mem(32'hBFC0_0000));

    // Simultaneous requests: data first, then instruction; out-of-order return
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h100; inst_sram_size = 2;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h200; data_sram_size = 1;
    smp(); check("prio_data_ok", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b10);
    cyc(); data_sram_req = 0;
    smp(); check("prio_inst_ok", inst_sram_addr_ok, 1);
    check("prio_ar_data", {axi.arid, axi.araddr, axi.arsize}, {4'd1, 32'h200, 3'd1});
    cyc(); inst_sram_req = 0;
    smp(); check("prio_ar_inst", {axi.arid, axi.araddr}, {4'd0, 32'h100});
    ret(4'd0, 32'h100);
    smp(); check("ooo_inst_first", {inst_sram_data_ok, data_sram_data_ok}, 2'b10);
    ret(4'd1, 32'h200);
    smp(); check("ooo_data_second", {inst_sram_data_ok, data_sram_data_ok}, 2'b01);
    check("ooo_data_rdata", data_sram_rdata, mem(32'h200));

    // Outstanding limit
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1000; inst_sram_size = 2;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      smp(); if (inst_sram_addr_ok) cnt++;
      cyc();
    end
    check("limit_accepts", cnt, OUT);
    axi.rvalid = 1; axi.rid = 0; axi.rdata = mem(32'h1000);
    smp(); check("limit_no_comb_path", inst_sram_addr_ok, 0);
    cyc(); axi.rvalid = 0;
    smp(); check("limit_reaccept", inst_sram_addr_ok, 1);
    cyc(); inst_sram_req = 0;
    for (int i = 0; i < OUT; i++) ret(4'd0, 32'h1000);
    smp(); check("limit_drained", rd_outstanding, 0);

    // arready stall
    cyc(); data_sram_req = 1; data_sram_addr = 32'h300; data_sram_size = 2; axi.arready = 0;
    smp(); check("stall_first_ok", data_sram_addr_ok, 1);
    cyc(); data_sram_addr = 32'h304;
    for (int i = 0; i < 5; i++) begin
      smp();
      check("stall_hold", {axi.arvalid, axi.arid, axi.araddr, axi.arsize, data_sram_addr_ok},
            {1'b1, 4'd1, 32'h300, 3'd2, 1'b0});
      cyc();
    end
    axi.arready = 1;
    smp(); check("stall_release", data_sram_addr_ok, 1);
    cyc(); data_sram_req = 0;
    smp(); check("stall_next_ar", axi.araddr, 32'h304);
    ret(4'd1, 32'h300);
    ret(4'd1, 32'h304);

    // Data write beside instruction read, unknown-ID beat
    cyc(); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h400;
    inst_sram_req = 1; inst_sram_addr = 32'h500;
    smp(); check("wr_addr_ok", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b01);
    cyc(); data_sram_req = 0; data_sram_wr = 0; inst_sram_req = 0;
    ret(4'd5, 32'hDEAD_0000);
    smp(); check("junk_no_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    check("junk_rd_out", rd_outstanding, 1);
    ret(4'd0, 32'h500);
    smp(); check("wr_inst_data_ok", inst_sram_data_ok, 1);
    check("junk_count_kept", rd_outstanding, 0);

    // Reset with three reads in flight
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h600;
    cyc(); inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h700;
    cyc(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h604;
    cyc(); inst_sram_req = 0;
    smp(); check("mid_rd_out", rd_outstanding, 1);
    cyc(); reset = 1;
    cyc(); smp();
    check_reset_vals("mid_rst");
    cyc(); reset = 0;
    cyc(); smp();
    check("mid_rready", axi.rready, 1);
    check("mid_rd_out_clear", rd_outstanding, 0);

    // Randomized traffic against the slave model
    drained = 0;
    for (int c = 0; c < 3600; c++) begin
      gen = (c < 3000);
      @(negedge clk);
      if (axi.arvalid && axi.arready) begin
        if (axi.arid == 4'd0) pend_i.push_back(axi.araddr);
        else if (axi.arid == 4'd1) pend_d.push_back(axi.araddr);
      end
      if (!gen && pend_i.size() == 0 && pend_d.size() == 0 && !axi.rvalid && !rd_outstanding) begin
        drained = 1;
        break;
      end
      @(posedge clk); #1;
      inst_sram_req  = gen && ($urandom % 4 != 0);
      inst_sram_addr = $urandom & 32'hFFFF_FFFC;
      inst_sram_size = 2'($urandom_range(0, 2));
      data_sram_req  = gen && ($urandom % 3 != 0);
      data_sram_wr   = ($urandom % 4 == 0);
      data_sram_addr = $urandom & 32'hFFFF_FFFC;
      data_sram_size = 2'($urandom_range(0, 2));
      axi.arready    = ($urandom % 4 != 0);
      axi.rvalid     = 0;
      axi.rresp      = 2'($urandom);
      axi.rlast      = 1'($urandom);
      sel = $urandom % 8;
      if (sel == 0) begin
        axi.rvalid = 1; axi.rid = 4'd5; axi.rdata = $urandom;
      end else if (sel < 4 && pend_i.size() > 0) begin
        axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = mem(pend_i.pop_front());
      end else if (sel >= 4 && pend_d.size() > 0) begin
        axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = mem(pend_d.pop_front());
      end
    end
    check("random_drain_in_budget", drained, 1);
    repeat (3) smp();
    check("random_inst_all_returned", q_i.size(), 0);
    check("random_data_all_returned", q_d.size(), 0);
    check("random_ar_all_issued", ar_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
